// File: rtl/prog_downtimer.sv
// -----------------------------------------------------------------------------
// prog_downtimer
//   Programmable down-timer used as a delay / periodic tick source next to the
//   CPU datapath. A loadable counter is stepped by a prescaled enable. On the
//   terminal tick (Q==1) it either stops at zero (one-shot) or reloads
//   (auto-reload). It raises a one-cycle terminal-count pulse and a sticky flag.
//
//   Parameters
//     WIDTH   counter / load / reload width
//     PWIDTH  prescaler compare width (divide ratio = PSC+1)
//
//   Ports
//     CLK     in   1       clock; all state updates on the rising edge
//     RST     in   1       synchronous active-high reset; overrides everything
//     D       in   WIDTH   load value
//     LD      in   1       load D into counter and reload register, restart
//     EN      in   1       count enable; gates both prescaler and counter
//     MODE    in   1       0 = one-shot, 1 = auto-reload (sampled at terminal)
//     PSC     in   PWIDTH  prescale compare; counter ticks every PSC+1 enables
//     CLR_TC  in   1       clear the sticky FLAG
//     Q       out  WIDTH   current count (registered)
//     TC      out  1       terminal-count pulse, one cycle (registered)
//     FLAG    out  1       sticky terminal-count flag (registered)
//     RUN     out  1       timer armed and allowed to count (registered)
// -----------------------------------------------------------------------------
module prog_downtimer #(
  parameter int WIDTH  = 32,
  parameter int PWIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  D,
  input  logic              LD,
  input  logic              EN,
  input  logic              MODE,
  input  logic [PWIDTH-1:0] PSC,
  input  logic              CLR_TC,
  output logic [WIDTH-1:0]  Q,
  output logic              TC,
  output logic              FLAG,
  output logic              RUN
);

  // State registers and their next-state values
  logic [WIDTH-1:0]  q_q,      q_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic [PWIDTH-1:0] pcnt_q,   pcnt_d;
  logic              run_q,    run_d;
  logic              tc_q,     tc_d;
  logic              flag_q,   flag_d;

  // Decoded control conditions
  logic step_s;      // prescaler is allowed to advance this cycle
  logic tick_s;      // prescaler wraps: counter steps this cycle
  logic terminal_s;  // tick while counter sits at 1

  // Decode of the step / tick / terminal conditions
  always_comb begin
    step_s     = 1'b0;
    tick_s     = 1'b0;
    terminal_s = 1'b0;
    if (!LD && EN && run_q) begin
      step_s = 1'b1;
      // ">=" rather than "==": lowering PSC below the current pcnt ticks at
      // once instead of running pcnt all the way round its range.
      if (pcnt_q >= PSC) begin
        tick_s = 1'b1;
      end else begin
        tick_s = 1'b0;
      end
      if ((pcnt_q >= PSC) && (q_q == WIDTH'(1))) begin
        terminal_s = 1'b1;
      end else begin
        terminal_s = 1'b0;
      end
    end else begin
      step_s     = 1'b0;
      tick_s     = 1'b0;
      terminal_s = 1'b0;
    end
  end

  // Next-state logic for counter, reload value, prescaler and run state
  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    pcnt_d   = pcnt_q;
    run_d    = run_q;
    tc_d     = 1'b0;

    if (LD) begin
      // Load wins over counting; a zero load leaves the timer disarmed.
      q_d      = D;
      reload_d = D;
      pcnt_d   = '0;
      run_d    = (D != '0);
    end else if (step_s) begin
      if (tick_s) begin
        pcnt_d = '0;
        if (terminal_s) begin
          tc_d = 1'b1;
          if (MODE) begin
            q_d   = reload_q;
            run_d = 1'b1;
          end else begin
            q_d   = '0;
            run_d = 1'b0;
          end
        end else if (q_q > WIDTH'(1)) begin
          q_d = q_q - WIDTH'(1);
        end else begin
          // Q==0 while running cannot arise; hold rather than wrap.
          q_d = q_q;
        end
      end else begin
        pcnt_d = pcnt_q + PWIDTH'(1);
      end
    end else begin
      // Disabled or disarmed: everything holds.
      q_d    = q_q;
      pcnt_d = pcnt_q;
    end
  end

  // Sticky flag: a new terminal event takes priority over a clear request
  always_comb begin
    flag_d = flag_q;
    if (tc_d) begin
      flag_d = 1'b1;
    end else if (CLR_TC) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q      <= '0;
      reload_q <= '0;
      pcnt_q   <= '0;
      run_q    <= 1'b0;
      tc_q     <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      pcnt_q   <= pcnt_d;
      run_q    <= run_d;
      tc_q     <= tc_d;
      flag_q   <= flag_d;
    end
  end

  // Outputs come straight from flops
  assign Q    = q_q;
  assign TC   = tc_q;
  assign FLAG = flag_q;
  assign RUN  = run_q;

endmodule

// File: tb/tb_prog_downtimer.sv
// -----------------------------------------------------------------------------
// tb_prog_downtimer
//   Directed bench for prog_downtimer with hand-computed expected values.
//   Inputs change 1 ns after a rising edge; outputs are checked at that point,
//   so every check sees the state produced by the edge just passed.
// -----------------------------------------------------------------------------
module tb_prog_downtimer;

  localparam int WIDTH  = 32;
  localparam int PWIDTH = 8;

  logic              clk;
  logic              rst;
  logic [WIDTH-1:0]  d;
  logic              ld;
  logic              en;
  logic              mode;
  logic [PWIDTH-1:0] psc;
  logic              clr_tc;
  logic [WIDTH-1:0]  q;
  logic              tc;
  logic              flag;
  logic              run;

  int n_cmp;
  int n_err;

  prog_downtimer #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) dut (
    .CLK    (clk),
    .RST    (rst),
    .D      (d),
    .LD     (ld),
    .EN     (en),
    .MODE   (mode),
    .PSC    (psc),
    .CLR_TC (clr_tc),
    .Q      (q),
    .TC     (tc),
    .FLAG   (flag),
    .RUN    (run)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all four outputs at once
  task automatic check_all(input string tag, input logic [31:0] eq, input logic etc,
                           input logic eflag, input logic erun);
    check({tag, ".Q"},    q,    eq);
    check({tag, ".TC"},   {31'd0, tc},   {31'd0, etc});
    check({tag, ".FLAG"}, {31'd0, flag}, {31'd0, eflag});
    check({tag, ".RUN"},  {31'd0, run},  {31'd0, erun});
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    d      = 32'd0;
    ld     = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    psc    = 8'd0;
    clr_tc = 1'b0;

    // 1: reset, one-shot count 3,2,1,0
    tick();
    check_all("rst", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; ld = 1'b1; d = 32'd3; mode = 1'b0; psc = 8'd0;
    tick();
    check_all("os_ld", 32'd3, 1'b0, 1'b0, 1'b1);
    ld = 1'b0; en = 1'b1;
    tick(); check_all("os_2", 32'd2, 1'b0, 1'b0, 1'b1);
    tick(); check_all("os_1", 32'd1, 1'b0, 1'b0, 1'b1);
    tick(); check_all("os_0", 32'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_all("os_stop", 32'd0, 1'b0, 1'b1, 1'b0);
    tick(); check_all("os_stop2", 32'd0, 1'b0, 1'b1, 1'b0);

    // 2: auto-reload 2,1,2,1 with LD and EN together
    ld = 1'b1; d = 32'd2; mode = 1'b1; en = 1'b1;
    tick(); check_all("ar_ld", 32'd2, 1'b0, 1'b1, 1'b1);
    ld = 1'b0;
    tick(); check_all("ar_1a", 32'd1, 1'b0, 1'b1, 1'b1);
    tick(); check_all("ar_2a", 32'd2, 1'b1, 1'b1, 1'b1);
    tick(); check_all("ar_1b", 32'd1, 1'b0, 1'b1, 1'b1);
    tick(); check_all("ar_2b", 32'd2, 1'b1, 1'b1, 1'b1);

    // 3: prescale by 3, with an EN gap mid-period
    ld = 1'b1; d = 32'd2; psc = 8'd2;
    tick(); check("ps_ld", q, 32'd2);
    ld = 1'b0;
    tick(); check("ps_p1", q, 32'd2);
    tick(); check("ps_p2", q, 32'd2);
    tick(); check("ps_step", q, 32'd1);
    tick(); check("ps_p1b", q, 32'd1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ps_hold", q, 32'd1);
      check("ps_hold_tc", {31'd0, tc}, 32'd0);
    end
    en = 1'b1;
    tick(); check("ps_resume", q, 32'd1);
    tick(); check_all("ps_reload", 32'd2, 1'b1, 1'b1, 1'b1);

    // 3b: lowering PSC below the current pcnt ticks immediately
    ld = 1'b1; d = 32'd3; psc = 8'd3; mode = 1'b0;
    tick(); check("psl_ld", q, 32'd3);
    ld = 1'b0;
    tick(); tick();
    check("psl_wait", q, 32'd3);
    psc = 8'd1;
    tick(); check("psl_step", q, 32'd2);
    psc = 8'd0;

    // 4: LD while running restarts; LD D=0 disarms without TC
    ld = 1'b1; d = 32'd6;
    tick(); ld = 1'b0;
    tick(); tick();
    check("rl_q4", q, 32'd4);
    ld = 1'b1; d = 32'd5;
    tick(); check_all("rl_q5", 32'd5, 1'b0, 1'b1, 1'b1);
    d = 32'd0;
    tick(); check_all("ld0", 32'd0, 1'b0, 1'b1, 1'b0);
    ld = 1'b0;
    tick(); check_all("ld0_hold", 32'd0, 1'b0, 1'b1, 1'b0);

    // 5: clear alone, then set wins over a coincident clear
    clr_tc = 1'b1;
    tick(); check("clr", {31'd0, flag}, 32'd0);
    clr_tc = 1'b0; ld = 1'b1; d = 32'd2; mode = 1'b0;
    tick(); ld = 1'b0;
    tick(); check("fl_q1", q, 32'd1);
    clr_tc = 1'b1;
    tick(); check_all("fl_setwin", 32'd0, 1'b1, 1'b1, 1'b0);
    tick(); check_all("fl_clr", 32'd0, 1'b0, 1'b0, 1'b0);
    clr_tc = 1'b0;

    // 6: reset mid-count in auto-reload mode, also against a pending LD
    ld = 1'b1; d = 32'd9; mode = 1'b1;
    tick(); ld = 1'b0;
    tick(); tick();
    check("mid_q7", q, 32'd7);
    rst = 1'b1; ld = 1'b1; d = 32'd5;
    tick(); check_all("mid_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; ld = 1'b0;
    tick(); check_all("post_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    tick(); check_all("post_rst2", 32'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
